// File: rtl/sap_microsequencer.sv
// Hardwired control sequencer for the SAP-1 datapath.
//
// A six-state one-hot ring counter (T1..T6) steps through fetch (T1..T3) and
// execute (T4..T6). The 12-bit control word is a Moore decode of the ring state
// and the IR opcode, gated to the NOP word during reset, while frozen
// (enable low) and once halted. An 8-bit counter tracks retired instructions.
//
// Ports:
//   clock        in   system clock, rising-edge active
//   reset        in   asynchronous active-low reset
//   enable       in   1 = advance one T-state per clock, 0 = freeze and emit NOP
//   instruction  in   [3:0] opcode from the instruction register
//   control_word out  [11:0] {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
//   t_state      out  [5:0] one-hot ring state, bit0 = T1
//   halted       out  high once HLT has executed
//   retired      out  [7:0] completed-instruction count (wraps)
module sap_microsequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  instruction,
  output logic [11:0] control_word,
  output logic [5:0]  t_state,
  output logic        halted,
  output logic [7:0]  retired
);

  // Active-low strobes (Lm, Ce, Li, Ei, La, Lb, Lo) sit at 1 in the idle word.
  localparam logic [11:0] NopWord    = 12'h3E3;
  localparam logic [11:0] FetchT1    = 12'h5E3; // Ep, Lm
  localparam logic [11:0] FetchT2    = 12'hBE3; // Cp
  localparam logic [11:0] FetchT3    = 12'h263; // Ce, Li
  localparam logic [11:0] AddrToMar  = 12'h1A3; // Ei, Lm
  localparam logic [11:0] RamToA     = 12'h2C3; // Ce, La
  localparam logic [11:0] RamToB     = 12'h2E1; // Ce, Lb
  localparam logic [11:0] SumToA     = 12'h3C7; // Eu, La
  localparam logic [11:0] DiffToA    = 12'h3CF; // Su, Eu, La
  localparam logic [11:0] AToOut     = 12'h3F2; // Ea, Lo

  typedef enum logic [5:0] {
    StT1 = 6'b000001,
    StT2 = 6'b000010,
    StT3 = 6'b000100,
    StT4 = 6'b001000,
    StT5 = 6'b010000,
    StT6 = 6'b100000
  } state_e;

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic [7:0]  retired_q, retired_d;
  logic [11:0] decoded_word;
  logic        advance;

  assign advance = enable & ~halted_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StT1;
      halted_q  <= 1'b0;
      retired_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // Next-state: rotate the ring; HLT latches at the end of T4 so the ring
  // parks in T5. Any non-one-hot vector falls back to T1.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    if (advance) begin
      case (state_q)
        StT1: state_d = StT2;
        StT2: state_d = StT3;
        StT3: state_d = StT4;
        StT4: begin
          state_d = StT5;
          if (instruction == OP_HLT) begin
            halted_d = 1'b1;
          end
        end
        StT5: state_d = StT6;
        StT6: begin
          state_d   = StT1;
          retired_d = retired_q + 8'd1;
        end
        default: state_d = StT1;
      endcase
    end
  end

  // Opcode is only looked at in T4..T6; the IR is still loading during T3.
  always_comb begin
    decoded_word = NopWord;
    case (state_q)
      StT1: decoded_word = FetchT1;
      StT2: decoded_word = FetchT2;
      StT3: decoded_word = FetchT3;
      StT4: begin
        case (instruction)
          OP_LDA, OP_ADD, OP_SUB: decoded_word = AddrToMar;
          OP_OUT:                 decoded_word = AToOut;
          default:                decoded_word = NopWord;
        endcase
      end
      StT5: begin
        case (instruction)
          OP_LDA:         decoded_word = RamToA;
          OP_ADD, OP_SUB: decoded_word = RamToB;
          default:        decoded_word = NopWord;
        endcase
      end
      StT6: begin
        case (instruction)
          OP_ADD:  decoded_word = SumToA;
          OP_SUB:  decoded_word = DiffToA;
          default: decoded_word = NopWord;
        endcase
      end
      default: decoded_word = NopWord;
    endcase
  end

  // Reset is folded in combinationally so the bus idles immediately on assert.
  always_comb begin
    control_word = NopWord;
    if (reset && advance) begin
      control_word = decoded_word;
    end
  end

  assign t_state = state_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule
